dac_serial_tx: RTL and testbench

- Downstream output stage of the ZOH interpolation pipeline. Consumes 20-bit signed interpolated samples, one strobe per sample.
- Shifts each sample MSB-first to an external serial DAC. Generates the serial bit clock `clk_out` and the latch-enable pulse `LE`.
- Contains a single-entry pending buffer, so a sample arriving mid-frame is kept rather than dropped.

---
 rtl/dac_tx_pkg.sv | 23 ++
 rtl/dac_serial_tx_sclk_gen.sv | 52 +++++
 rtl/dac_serial_tx.sv | 169 ++++++++++++++++
 tb/tb_dac_serial_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dac_tx_pkg.sv
// dac_tx_pkg: shared types and defaults for the serial DAC transmitter.
// frame_cycles() gives strobe-edge to LE-falling-edge length in CLK cycles.
package dac_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } dac_state_e;

    localparam int DAC_DATA_W    = 20;
    localparam int DAC_CLK_DIV   = 4;
    localparam int DAC_LE_CYCLES = 2;

    function automatic int frame_cycles(
        input int data_w,
        input int clk_div,
        input int le_cycles
    );
        return 1 + 2 * clk_div * data_w + le_cycles;
    endfunction

endpackage

// File: rtl/dac_serial_tx_sclk_gen.sv
// sclk_gen: divided DAC bit clock with one-cycle edge strobes.
// rise_o/fall_o flag the CLK edge on which sclk_o is about to toggle.
module sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic restart_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          term;

    assign term   = (cnt_q == CW'(CLK_DIV - 1));
    assign rise_o = en_i && !restart_i && term && !sclk_q;
    assign fall_o = en_i && !restart_i && term && sclk_q;
    assign sclk_o = sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (restart_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (en_i) begin
            if (term) begin
                cnt_d  = '0;
                sclk_d = ~sclk_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/dac_serial_tx.sv
// dac_serial_tx: MSB-first serial DAC shifter with one-entry pending buffer.
// Define DAC_OFFSET_BINARY_EN to invert each sample's MSB at load (offset binary).
module dac_serial_tx
    import dac_tx_pkg::*;
#(
    parameter int DATA_W    = DAC_DATA_W,
    parameter int CLK_DIV   = DAC_CLK_DIV,
    parameter int LE_CYCLES = DAC_LE_CYCLES
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_stb,
    input  logic              clr_overrun,
    output logic              serial_out,
    output logic              clk_out,
    output logic              LE,
    output logic              busy,
    output logic              overrun
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam int LW = $clog2(LE_CYCLES + 1);

    dac_state_e        state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] pend_q;
    logic              pend_full_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [LW-1:0]     le_cnt_q;
    logic              first_q;
    logic              last_q;
    logic              serial_q;
    logic              le_q;
    logic              busy_q;
    logic              ovr_q;

    logic              le_done;
    logic              drain;
    logic              load;
    logic              store;
    logic              ovr_set;
    logic [DATA_W-1:0] load_src;
    logic [DATA_W-1:0] load_w;
    logic              sclk_en;
    logic              sclk_rise;
    logic              sclk_fall;

    assign le_done = (state_q == LATCH) && (le_cnt_q == LW'(LE_CYCLES - 1));
    assign drain   = le_done && pend_full_q;

    // A strobe landing as an empty-buffer frame ends starts the next frame directly.
    assign load = ((state_q == IDLE) && sample_stb)
               || drain
               || (le_done && sample_stb);

    assign store    = sample_stb && busy_q && !(le_done && !pend_full_q);
    assign ovr_set  = store && pend_full_q && !drain;
    assign load_src = drain ? pend_q : sample_in;

`ifdef DAC_OFFSET_BINARY_EN
    assign load_w = {~load_src[DATA_W-1], load_src[DATA_W-2:0]};
`else
    assign load_w = load_src;
`endif

    // The first SHIFT cycle holds the divider so the MSB gets its load cycle.
    assign sclk_en = (state_q == SHIFT) && !first_q;

    sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .en_i      (sclk_en),
        .restart_i (load),
        .sclk_o    (clk_out),
        .rise_o    (sclk_rise),
        .fall_o    (sclk_fall)
    );

    assign serial_out = serial_q;
    assign LE         = le_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            le_cnt_q    <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            serial_q    <= 1'b0;
            le_q        <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            first_q <= load;

            if (store) begin
                pend_q      <= sample_in;
                pend_full_q <= 1'b1;
            end else if (drain) begin
                pend_full_q <= 1'b0;
            end

            if (ovr_set) begin
                ovr_q <= 1'b1;
            end else if (clr_overrun) begin
                ovr_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        shreg_q   <= load_w;
                        serial_q  <= load_w[DATA_W-1];
                        bit_cnt_q <= '0;
                        last_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        last_q <= (bit_cnt_q == BW'(DATA_W - 1));
                    end
                    if (sclk_fall) begin
                        if (last_q) begin
                            serial_q <= 1'b0;
                            le_q     <= 1'b1;
                            le_cnt_q <= '0;
                            state_q  <= LATCH;
                        end else begin
                            shreg_q   <= {shreg_q[DATA_W-2:0], 1'b0};
                            serial_q  <= shreg_q[DATA_W-2];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (le_done) begin
                        le_q <= 1'b0;
                        if (load) begin
                            shreg_q   <= load_w;
                            serial_q  <= load_w[DATA_W-1];
                            bit_cnt_q <= '0;
                            last_q    <= 1'b0;
                            state_q   <= SHIFT;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        le_cnt_q <= le_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_serial_tx.sv
// tb_dac_serial_tx: directed scoreboard bench for dac_serial_tx.
// Stimulus pushes expected words; a monitor reassembles frames and compares.
module tb_dac_serial_tx;
    import dac_tx_pkg::*;

    localparam int FRAME = 83;

`ifdef DAC_OFFSET_BINARY_EN
    localparam logic [19:0] NEG_EXP = 20'h7D8F0;
`else
    localparam logic [19:0] NEG_EXP = 20'hFD8F0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [19:0] sample_in = '0;
    logic        sample_stb = 1'b0;
    logic        clr_overrun = 1'b0;
    logic        serial_out;
    logic        clk_out;
    logic        LE;
    logic        busy;
    logic        overrun;

    dac_serial_tx #(
        .DATA_W    (20),
        .CLK_DIV   (2),
        .LE_CYCLES (2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .sample_in   (sample_in),
        .sample_stb  (sample_stb),
        .clr_overrun (clr_overrun),
        .serial_out  (serial_out),
        .clk_out     (clk_out),
        .LE          (LE),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int stb_cyc  = 0;
    int last_fall = 0;
    int prev_fall = 0;
    int nbits    = 0;
    int le_w     = 0;
    logic [19:0] word = '0;
    logic prev_clk = 1'b0;
    logic prev_le  = 1'b0;
    logic [19:0] exp_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    function automatic logic [19:0] ob(input logic [19:0] x);
`ifdef DAC_OFFSET_BINARY_EN
        return {~x[19], x[18:0]};
`else
        return x;
`endif
    endfunction

    always @(negedge CLK) begin
        if (!RST) begin
            word = '0;
            nbits = 0;
            le_w = 0;
            prev_clk = 1'b0;
            prev_le = 1'b0;
        end else begin
            if (clk_out && !prev_clk) begin
                word = {word[18:0], serial_out};
                nbits++;
            end
            if (LE) le_w++;
            if (prev_le && !LE) begin
                prev_fall = last_fall;
                last_fall = cyc - 1;
                chk("frame_bits", nbits, 20);
                chk("le_width", le_w, 2);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL frame_unexpected: got 0x%0h, want none", word);
                end else begin
                    chk("frame_word", word, exp_q.pop_front());
                end
                word = '0;
                nbits = 0;
                le_w = 0;
            end
            prev_clk = clk_out;
            prev_le = LE;
        end
    end

    task automatic strobe(input logic [19:0] v);
        @(posedge CLK);
        #1;
        sample_in = v;
        sample_stb = 1'b1;
        @(posedge CLK);
        stb_cyc = cyc;
        #1;
        sample_stb = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk(nm, (n >= 400), 0);
    endtask

    initial begin
        real r;
        int iv;
        logic [19:0] w;
        int n;

        #12;
        chk("rst_serial", serial_out, 0);
        chk("rst_clk", clk_out, 0);
        chk("rst_le", LE, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(posedge CLK);

        // single sample
        exp_q.push_back(ob(20'h00064));
        strobe(20'h00064);
        chk("t1_busy_on", busy, 1);
        wait_idle("t1_timeout");
        chk("t1_latency", last_fall - stb_cyc, frame_cycles(20, 2, 2));
        chk("t1_busy_off", busy, 0);

        // negative sample
        exp_q.push_back(NEG_EXP);
        strobe(20'hFD8F0);
        wait_idle("t2_timeout");
        chk("t2_latency", last_fall - stb_cyc, FRAME);

        // back-to-back
        exp_q.push_back(ob(20'h0079E));
        exp_q.push_back(ob(20'h00EF2));
        strobe(20'h0079E);
        repeat (8) @(posedge CLK);
        strobe(20'h00EF2);
        chk("t3_ovr_mid", overrun, 0);
        wait_idle("t3_timeout");
        chk("t3_gap", last_fall - prev_fall, FRAME);
        chk("t3_ovr", overrun, 0);

        // overrun
        exp_q.push_back(ob(20'h015B3));
        exp_q.push_back(ob(20'h0207A));
        strobe(20'h015B3);
        repeat (8) @(posedge CLK);
        strobe(20'h01B9F);
        chk("t4_ovr_pre", overrun, 0);
        repeat (8) @(posedge CLK);
        strobe(20'h0207A);
        chk("t4_ovr_set", overrun, 1);
        wait_idle("t4_timeout");
        chk("t4_gap", last_fall - prev_fall, FRAME);
        chk("t4_ovr_hold", overrun, 1);
        @(posedge CLK);
        #1 clr_overrun = 1'b1;
        @(posedge CLK);
        #1 clr_overrun = 1'b0;
        chk("t4_ovr_clr", overrun, 0);

        // reset mid-frame
        strobe(20'h03039);
        n = 0;
        while (nbits < 7 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("t5_reach_bit7", (n >= 200), 0);
        #2 RST = 1'b0;
        #1;
        chk("t5_clk", clk_out, 0);
        chk("t5_le", LE, 0);
        chk("t5_serial", serial_out, 0);
        chk("t5_busy", busy, 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        chk("t5_idle_after", busy, 0);
        exp_q.push_back(ob(20'h0264F));
        strobe(20'h0264F);
        wait_idle("t5_timeout");
        chk("t5_latency", last_fall - stb_cyc, FRAME);

        // sine sweep
        for (int k = 0; k < 34; k++) begin
            r = 10000.0 * $sin(2.0 * 3.14159265358979 * k / 34.0);
            iv = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
            w = iv[19:0];
            exp_q.push_back(ob(w));
            strobe(w);
            repeat (88) @(posedge CLK);
        end
        wait_idle("t6_timeout");
        chk("t6_ovr", overrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
